tx_payload_sequencer: RTL and testbench
=======================================

Name: tx_payload_sequencer

Overview:
- Sits on the 125 MHz Ethernet TX side, between the dual-port RGB VRAMs (B port) and the UDP/Ethernet frame builder.
- On a start pulse for one segment, it generates VRAM B-port pixel addresses and the colour-plane select, and absorbs the fixed VRAM read latency.
- It emits one segment payload as a byte stream with a valid/ready handshake: a 2-byte segment header, then R,G,B bytes per pixel.

Parameters:
- PIXELS_PER_SEG, 480, pixels per segment (payload = 2 + 3*PIXELS_PER_SEG bytes; 1442 at default).
- NUM_SEGS, 4320, segments per frame (1920*1080/480); valid seg_num range is 0..NUM_SEGS-1.
- ADDR_W, 21, VRAM B-port address width.
- RD_LAT, 2, VRAM B-port read latency in cycles (address in to data out).
- FIFO_DEPTH, 8, skid FIFO entries; must be >= RD_LAT+2.

Ports:
- clk125MHz  in  1  Ethernet TX clock; the only clock.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to send one segment.
- seg_num  in  13  segment number, sampled on an accepted start.
- busy  out  1  high from accepted start until the last byte is accepted.
- err_start  out  1  1-cycle pulse when start is rejected.
- vram_addr  out  ADDR_W  VRAM B-port pixel address.
- vram_sel  out  2  colour plane of the byte being read: 0=R, 2=G, 1=B.
- vram_rd_data  in  8  selected VRAM byte, valid RD_LAT cycles after vram_addr/vram_sel.
- tdata  out  8  payload byte.
- tvalid  out  1  tdata valid.
- tready  in  1  frame builder accepts the byte; a transfer occurs when tvalid && tready.
- tlast  out  1  marks the final payload byte.
- done  out  1  1-cycle pulse in the cycle after the last transfer.

Behaviour:
- Reset (async, rstn=0): FSM goes to IDLE; FIFO and all counters are cleared; the RD_LAT in-flight tracking pipe is cleared. All outputs are 0: busy, err_start, vram_addr, vram_sel, tdata, tvalid, tlast, done.
- Reset mid-segment: the transfer is abandoned with no done pulse. After rstn deasserts, the block is idle and accepts a new start.
- Start acceptance: start is accepted only in IDLE with seg_num < NUM_SEGS.
  - If start arrives in IDLE with seg_num >= NUM_SEGS: err_start pulses, the block stays in IDLE, and no reads are issued.
  - If start arrives while busy: err_start pulses and the current transfer is unaffected.
- On accept:
  - Latch base = seg_num*PIXELS_PER_SEG (registered multiply, ADDR_W bits).
  - Clear pix_cnt and byte_cnt.
  - busy goes to 1 in the next cycle.
- FSM: IDLE -> HDR_HI -> HDR_LO -> DATA -> IDLE.
  - HDR_HI: tdata = {3'b0, seg_num_latched[12:8]}, tvalid=1.
  - HDR_LO: tdata = seg_num_latched[7:0], tvalid=1.
  - Each header state advances on a transfer.
  - DATA: tdata/tvalid are driven from the FIFO head; tvalid = FIFO not empty.
- Prefetch:
  - Starts the cycle after accept and runs in parallel with the header states.
  - A read is issued in any cycle where (fifo_count + inflight) < FIFO_DEPTH and reads remain.
  - Read issue order per pixel: sel 0, 2, 1, all at vram_addr = base + pix_cnt. pix_cnt increments after sel 1.
  - Total reads = 3*PIXELS_PER_SEG. After the last read is issued, no further addresses change.
  - Each issued read enters an RD_LAT-deep valid pipe. When it emerges, vram_rd_data is pushed into the FIFO. Because of the credit check, the FIFO never overflows.
  - FIFO push and pop in the same cycle are both allowed (count unchanged), including when the FIFO is full.
- tlast is 1 exactly with the byte where byte_cnt == 3*PIXELS_PER_SEG-1, in DATA.
- On the tlast transfer:
  - FSM returns to IDLE and busy drops in the next cycle.
  - done pulses in that same next cycle.
  - A start in the cycle busy is low is accepted.
- tready low: tvalid and tdata hold stable (AXI-stream rule). Prefetch stalls once credits are exhausted.
- tvalid never drops without a transfer, except on reset.
- Width rules:
  - pix_cnt and byte_cnt are sized with clog2 of 3*PIXELS_PER_SEG.
  - base+pix_cnt is truncated to ADDR_W bits; the design-time check is NUM_SEGS*PIXELS_PER_SEG <= 2**ADDR_W.

Decomposition:
- Shared package tx_pkg holds:
  - Plane select constants SEL_R=2'd0, SEL_G=2'd2, SEL_B=2'd1.
  - The FSM state enum.
  - Header length HDR_BYTES=2.
  - Default frame geometry: 1920, 1080, PIXELS_PER_SEG, NUM_SEGS.
- One sub-module: tx_sync_fifo. It is a parameterised width/depth synchronous FIFO with count output and simultaneous push/pop, used as the skid buffer.

Test Plan:
1. PIXELS_PER_SEG=4, RD_LAT=2, tready=1, VRAM model returns data = {addr[4:0], sel}. Start with seg_num=3:
   - Bytes out: 0x00, 0x03, then the R,G,B bytes for addresses 12..15, 12 payload bytes.
   - tlast on byte 14 of 14; done 1 cycle later.
   - Reads issued in order (12,0), (12,2), (12,1), (13,0), ...
2. Same setup, tready toggling 1-0-0-1 pseudo-randomly: identical byte sequence.
   - tdata is stable while tvalid && !tready.
   - FIFO count never exceeds FIFO_DEPTH (assertion).
3. seg_num=NUM_SEGS (4320) at default parameters: err_start pulses once; busy, tvalid and vram_addr stay 0.
4. Start again at byte 5 of a transfer: err_start pulses; the stream completes unchanged with 1442 bytes and one done.
5. rstn low for 1 cycle at byte 7:
   - All outputs are 0 asynchronously.
   - No done pulse follows.
   - A new start with seg_num=0 yields header 0x00, 0x00 and addresses starting at 0.
6. Back-to-back segments: start with seg_num=1 asserted in the same cycle as the done of seg_num=0. It is accepted; the second stream begins with 0x00, 0x01 and base address 4 (PIXELS_PER_SEG=4).

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the Ethernet TX payload path: plane selects, FSM
// states, header length and default frame geometry.
package tx_pkg;

  localparam logic [1:0] SEL_R = 2'd0;
  localparam logic [1:0] SEL_G = 2'd2;
  localparam logic [1:0] SEL_B = 2'd1;

  localparam int HDR_BYTES = 2;

  localparam int FRAME_W            = 1920;
  localparam int FRAME_H            = 1080;
  localparam int DEF_PIXELS_PER_SEG = 480;
  localparam int DEF_NUM_SEGS       = FRAME_W * FRAME_H / DEF_PIXELS_PER_SEG;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA
  } tx_state_e;

  // Byte order within a pixel on the wire is R, G, B.
  function automatic logic [1:0] plane_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEL_R;
      2'd1:    return SEL_G;
      default: return SEL_B;
    endcase
  endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide, even when
// full, because the popped slot is read before the edge that overwrites it.
module tx_sync_fifo
  import tx_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CNT_FULL) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_payload_sequencer.sv
// Streams one video segment as [seg_hi, seg_lo, R,G,B per pixel], prefetching
// VRAM bytes through a credit-limited skid FIFO that absorbs read latency.
module tx_payload_sequencer
  import tx_pkg::*;
#(
  parameter int PIXELS_PER_SEG = DEF_PIXELS_PER_SEG,
  parameter int NUM_SEGS       = DEF_NUM_SEGS,
  parameter int ADDR_W         = 21,
  parameter int RD_LAT         = 2,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic              clk125MHz,
  input  logic              rstn,
  input  logic              start,
  input  logic [12:0]       seg_num,
  output logic              busy,
  output logic              err_start,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [1:0]        vram_sel,
  input  logic [7:0]        vram_rd_data,
  output logic [7:0]        tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              tlast,
  output logic              done,
  output tx_state_e         state_dbg
);

  localparam int TOTAL_BYTES = 3 * PIXELS_PER_SEG;
  localparam int CNT_W       = $clog2(TOTAL_BYTES);
  localparam int FCNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W        = $clog2(RD_LAT + 2);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(TOTAL_BYTES - 1);
  localparam logic [CNT_W-1:0]  PIX_END   = CNT_W'(PIXELS_PER_SEG);
  localparam logic [ADDR_W-1:0] PIX_MUL   = ADDR_W'(PIXELS_PER_SEG);
  localparam logic [31:0]       SEG_LIMIT = 32'(NUM_SEGS);
  localparam logic [31:0]       DEPTH_U   = 32'(FIFO_DEPTH);

  if (longint'(NUM_SEGS) * longint'(PIXELS_PER_SEG) > (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("frame does not fit in ADDR_W address bits");
  end
  if (FIFO_DEPTH < RD_LAT + 2) begin : g_depth_chk
    $error("FIFO_DEPTH must cover RD_LAT+2 entries");
  end

  tx_state_e          state;
  logic [12:0]        seg_q;
  logic [ADDR_W-1:0]  base;
  logic [CNT_W-1:0]   pix_cnt;
  logic [1:0]         sel_idx;
  logic [CNT_W-1:0]   byte_cnt;
  logic               rd_issue_q;
  logic [RD_LAT-1:0]  rd_pipe;
  logic [IF_W-1:0]    inflight;
  logic               issue;
  logic               xfer;
  logic               seg_ok;
  logic [7:0]         fifo_head;
  logic               fifo_empty;
  logic [FCNT_W-1:0]  fifo_count;

  tx_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .CNT_W(FCNT_W)) u_fifo (
    .clk   (clk125MHz),
    .rst_n (rstn),
    .push  (rd_pipe[RD_LAT-1]),
    .din   (vram_rd_data),
    .pop   (xfer && (state == ST_DATA)),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Every read still in flight already owns a FIFO slot, so pushes never overflow.
  always_comb begin
    inflight = IF_W'(rd_issue_q);
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IF_W'(rd_pipe[i]);
  end

  assign issue = (state != ST_IDLE) && (pix_cnt < PIX_END) &&
                 ((32'(fifo_count) + 32'(inflight)) < DEPTH_U);
  assign seg_ok    = (32'(seg_num) < SEG_LIMIT);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // Stream handshake: a byte moves on any cycle with tvalid && tready; once
  // tvalid rises, tvalid/tdata/tlast hold until that transfer happens.
  assign xfer = tvalid && tready;

  always_comb begin
    tvalid = 1'b0;
    tdata  = 8'd0;
    tlast  = 1'b0;
    case (state)
      ST_HDR_HI: begin
        tvalid = 1'b1;
        tdata  = {3'b000, seg_q[12:8]};
      end
      ST_HDR_LO: begin
        tvalid = 1'b1;
        tdata  = seg_q[7:0];
      end
      ST_DATA: begin
        tvalid = !fifo_empty;
        tdata  = fifo_empty ? 8'd0 : fifo_head;
        tlast  = !fifo_empty && (byte_cnt == LAST_BYTE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk125MHz or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      seg_q      <= '0;
      base       <= '0;
      pix_cnt    <= '0;
      sel_idx    <= '0;
      byte_cnt   <= '0;
      rd_issue_q <= 1'b0;
      rd_pipe    <= '0;
      vram_addr  <= '0;
      vram_sel   <= '0;
      err_start  <= 1'b0;
      done       <= 1'b0;
    end else begin
      err_start  <= start && (busy || !seg_ok);
      done       <= 1'b0;
      rd_issue_q <= issue;
      rd_pipe[0] <= rd_issue_q;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

      if (issue) begin
        vram_addr <= base + ADDR_W'(pix_cnt);
        vram_sel  <= plane_sel(sel_idx);
        if (sel_idx == 2'd2) begin
          sel_idx <= 2'd0;
          pix_cnt <= pix_cnt + CNT_W'(1);
        end else begin
          sel_idx <= sel_idx + 2'd1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start && seg_ok) begin
            seg_q    <= seg_num;
            base     <= ADDR_W'(seg_num) * PIX_MUL;
            pix_cnt  <= '0;
            sel_idx  <= '0;
            byte_cnt <= '0;
            state    <= ST_HDR_HI;
          end
        end
        ST_HDR_HI: if (xfer) state <= ST_HDR_LO;
        ST_HDR_LO: if (xfer) state <= ST_DATA;
        ST_DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (tlast) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_payload_sequencer.sv
// Bench: a small-segment instance (4 pixels) and a default-geometry instance,
// each fed by a VRAM model and checked against a byte scoreboard.
module tb_tx_payload_sequencer;

  localparam int P_A = 4;
  localparam int P_B = 480;

  logic clk;
  logic rstn;

  logic        a_start, a_busy, a_err, a_tvalid, a_tready, a_tlast, a_done;
  logic [12:0] a_seg;
  logic [20:0] a_addr;
  logic [1:0]  a_sel, a_state;
  logic [7:0]  a_rd, a_tdata, a_d1, a_d2;

  logic        b_start, b_busy, b_err, b_tvalid, b_tready, b_tlast, b_done;
  logic [12:0] b_seg;
  logic [20:0] b_addr;
  logic [1:0]  b_sel, b_state;
  logic [7:0]  b_rd, b_tdata, b_d1, b_d2;

  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];

  int checks, passes;
  int xfer_cnt_a, done_cnt_a, max_fifo_a;
  int xfer_cnt_b, done_cnt_b, max_fifo_b;
  logic hold_a, tlx_a, hold_b, tlx_b;
  logic [7:0] hold_d_a, hold_d_b;

  tx_payload_sequencer #(.PIXELS_PER_SEG(P_A)) dut_a (
    .clk125MHz(clk), .rstn(rstn), .start(a_start), .seg_num(a_seg),
    .busy(a_busy), .err_start(a_err), .vram_addr(a_addr), .vram_sel(a_sel),
    .vram_rd_data(a_rd), .tdata(a_tdata), .tvalid(a_tvalid), .tready(a_tready),
    .tlast(a_tlast), .done(a_done), .state_dbg(a_state)
  );

  tx_payload_sequencer dut_b (
    .clk125MHz(clk), .rstn(rstn), .start(b_start), .seg_num(b_seg),
    .busy(b_busy), .err_start(b_err), .vram_addr(b_addr), .vram_sel(b_sel),
    .vram_rd_data(b_rd), .tdata(b_tdata), .tvalid(b_tvalid), .tready(b_tready),
    .tlast(b_tlast), .done(b_done), .state_dbg(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #4 clk = ~clk;

  // VRAM models: two-cycle read latency, data = {addr[4:0], sel}
  always @(posedge clk) begin
    a_d1 <= {1'b0, a_addr[4:0], a_sel};
    a_d2 <= a_d1;
    b_d1 <= {1'b0, b_addr[4:0], b_sel};
    b_d2 <= b_d1;
  end
  assign a_rd = a_d2;
  assign b_rd = b_d2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard fill: header then R,G,B per pixel at base + p
  task automatic push_seg(input int which, input int seg, input int pix);
    logic [1:0]  sel_ord [3];
    logic [20:0] addr;
    logic [8:0]  v;
    int n;
    sel_ord = '{2'd0, 2'd2, 2'd1};
    n = 0;
    for (int h = 0; h < 2; h++) begin
      v = (h == 0) ? {1'b0, 3'b000, 5'(seg >> 8)} : {1'b0, 8'(seg)};
      if (which == 0) exp_a.push_back(v); else exp_b.push_back(v);
    end
    for (int p = 0; p < pix; p++) begin
      addr = 21'(seg * pix + p);
      for (int s = 0; s < 3; s++) begin
        n++;
        v = {(n == 3 * pix), 1'b0, addr[4:0], sel_ord[s]};
        if (which == 0) exp_a.push_back(v); else exp_b.push_back(v);
      end
    end
  endtask

  // monitors: sampled on the falling edge
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rstn) begin
      hold_a = 1'b0;
      tlx_a  = 1'b0;
    end else begin
      if (a_done || tlx_a) check("a_done_after_tlast", 32'(a_done), 32'(tlx_a));
      if (a_done) done_cnt_a++;
      if (hold_a) begin
        check("a_hold_valid", 32'(a_tvalid), 32'd1);
        check("a_hold_data", 32'(a_tdata), 32'(hold_d_a));
      end
      if (a_tvalid && a_tready) begin
        xfer_cnt_a++;
        check("a_sb_nonempty", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check("a_tdata", 32'(a_tdata), 32'(e[7:0]));
          check("a_tlast", 32'(a_tlast), 32'(e[8]));
        end
      end
      tlx_a    = a_tvalid && a_tready && a_tlast;
      hold_a   = a_tvalid && !a_tready;
      hold_d_a = a_tdata;
      if (int'(dut_a.fifo_count) > max_fifo_a) max_fifo_a = int'(dut_a.fifo_count);
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rstn) begin
      hold_b = 1'b0;
      tlx_b  = 1'b0;
    end else begin
      if (b_done || tlx_b) check("b_done_after_tlast", 32'(b_done), 32'(tlx_b));
      if (b_done) done_cnt_b++;
      if (hold_b) begin
        check("b_hold_valid", 32'(b_tvalid), 32'd1);
        check("b_hold_data", 32'(b_tdata), 32'(hold_d_b));
      end
      if (b_tvalid && b_tready) begin
        xfer_cnt_b++;
        check("b_sb_nonempty", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check("b_tdata", 32'(b_tdata), 32'(e[7:0]));
          check("b_tlast", 32'(b_tlast), 32'(e[8]));
        end
      end
      tlx_b    = b_tvalid && b_tready && b_tlast;
      hold_b   = b_tvalid && !b_tready;
      hold_d_b = b_tdata;
      if (int'(dut_b.fifo_count) > max_fifo_b) max_fifo_b = int'(dut_b.fifo_count);
    end
  end

  // driver tasks
  task automatic start_a(input int seg, input bit ok);
    @(negedge clk);
    a_start = 1'b1;
    a_seg   = 13'(seg);
    @(negedge clk);
    a_start = 1'b0;
    check("a_err_on_start", 32'(a_err), 32'(!ok));
    check("a_busy_on_start", 32'(a_busy), 32'(ok));
  endtask

  task automatic start_b(input int seg, input bit ok);
    @(negedge clk);
    b_start = 1'b1;
    b_seg   = 13'(seg);
    @(negedge clk);
    b_start = 1'b0;
    check("b_err_on_start", 32'(b_err), 32'(!ok));
    check("b_busy_on_start", 32'(b_busy), 32'(ok));
  endtask

  task automatic drain_a(input int budget, input bit rnd);
    int n;
    n = 0;
    while (!a_done && n < budget) begin
      @(negedge clk);
      if (rnd) a_tready = 1'($urandom_range(0, 1));
      n++;
    end
    a_tready = 1'b1;
    check("a_done_seen", 32'(a_done), 32'd1);
  endtask

  task automatic drain_b(input int budget);
    int n;
    n = 0;
    while (!b_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("b_done_seen", 32'(b_done), 32'd1);
  endtask

  task automatic wait_xfers_a(input int target, input int budget);
    int n;
    n = 0;
    while (xfer_cnt_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("a_reach_xfer", 32'(xfer_cnt_a >= target), 32'd1);
  endtask

  task automatic wait_xfers_b(input int target, input int budget);
    int n;
    n = 0;
    while (xfer_cnt_b < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("b_reach_xfer", 32'(xfer_cnt_b >= target), 32'd1);
  endtask

  initial begin
    int x0, d0;
    checks = 0; passes = 0;
    xfer_cnt_a = 0; done_cnt_a = 0; max_fifo_a = 0;
    xfer_cnt_b = 0; done_cnt_b = 0; max_fifo_b = 0;
    a_start = 1'b0; a_seg = '0; a_tready = 1'b1;
    b_start = 1'b0; b_seg = '0; b_tready = 1'b1;
    rstn = 1'b0;

    // reset state
    #3;
    check("a_rst_ctl", 32'({a_busy, a_err, a_tvalid, a_tlast, a_done, a_sel, a_tdata}), 32'd0);
    check("a_rst_addr", 32'(a_addr), 32'd0);
    check("b_rst_ctl", 32'({b_busy, b_err, b_tvalid, b_tlast, b_done, b_sel, b_tdata}), 32'd0);
    check("b_rst_addr", 32'(b_addr), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // 1: segment 3, tready held high
    push_seg(0, 3, P_A);
    start_a(3, 1'b1);
    drain_a(200, 1'b0);
    check("a_last_addr_seg3", 32'(a_addr), 32'd15);
    check("a_last_sel_seg3", 32'(a_sel), 32'd1);
    @(negedge clk);
    check("a_idle_after_done", 32'(a_busy), 32'd0);
    check("a_done_single", 32'(a_done), 32'd0);

    // 2: same segment with random back-pressure
    push_seg(0, 3, P_A);
    start_a(3, 1'b1);
    drain_a(600, 1'b1);

    // 3: out-of-range segment on the default instance
    start_b(4320, 1'b0);
    @(negedge clk);
    check("b_err_one_pulse", 32'(b_err), 32'd0);
    repeat (5) @(negedge clk);
    check("b_bad_idle", 32'({b_busy, b_tvalid}), 32'd0);
    check("b_bad_no_addr", 32'(b_addr), 32'd0);

    // 4: restart attempt at byte 5 of a full default segment
    push_seg(1, 10, P_B);
    x0 = xfer_cnt_b;
    d0 = done_cnt_b;
    start_b(10, 1'b1);
    wait_xfers_b(x0 + 5, 100);
    b_start = 1'b1;
    b_seg   = 13'd20;
    @(negedge clk);
    b_start = 1'b0;
    check("b_err_while_busy", 32'(b_err), 32'd1);
    check("b_busy_kept", 32'(b_busy), 32'd1);
    drain_b(6000);
    @(negedge clk);
    check("b_byte_total", 32'(xfer_cnt_b - x0), 32'd1442);
    check("b_done_total", 32'(done_cnt_b - d0), 32'd1);

    // 5: reset mid-segment
    push_seg(0, 7, P_A);
    x0 = xfer_cnt_a;
    start_a(7, 1'b1);
    wait_xfers_a(x0 + 7, 100);
    #2 rstn = 1'b0;
    #1;
    check("a_midrst_ctl", 32'({a_busy, a_err, a_tvalid, a_tlast, a_done, a_sel, a_tdata}), 32'd0);
    check("a_midrst_addr", 32'(a_addr), 32'd0);
    exp_a.delete();
    d0 = done_cnt_a;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("a_no_done_after_rst", 32'(done_cnt_a - d0), 32'd0);
    check("a_idle_after_rst", 32'(a_busy), 32'd0);

    // 5/6: segment 0 after reset, then segment 1 started on the done cycle
    push_seg(0, 0, P_A);
    start_a(0, 1'b1);
    drain_a(200, 1'b0);
    push_seg(0, 1, P_A);
    a_start = 1'b1;
    a_seg   = 13'd1;
    @(negedge clk);
    a_start = 1'b0;
    check("a_b2b_busy", 32'(a_busy), 32'd1);
    check("a_b2b_err", 32'(a_err), 32'd0);
    drain_a(200, 1'b0);
    check("a_last_addr_seg1", 32'(a_addr), 32'd7);
    @(negedge clk);

    // final report
    check("a_sb_empty", 32'(exp_a.size()), 32'd0);
    check("b_sb_empty", 32'(exp_b.size()), 32'd0);
    check("a_fifo_bound", 32'(max_fifo_a <= 8), 32'd1);
    check("b_fifo_bound", 32'(max_fifo_b <= 8), 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
